// File: rtl/plab5_mcore_dma_sec_arbiter_pkg.sv
// Shared definitions for the multi-channel DMA security arbiter: FSM states,
// response status codes, counter width and the per-channel slice helper.
`ifndef PLAB5_SLICE
`define PLAB5_SLICE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package plab5_mcore_dma_sec_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_DENIED  = 2'd1,
        STATUS_TIMEOUT = 2'd2
    } status_t;

    localparam int c_cnt_nbits = 16;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int idx_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plab5_mcore_dma_sec_arbiter_if.sv
// Command/completion channel between the security arbiter (master) and the
// DMA controller (slave).
interface plab5_mcore_dma_sec_arbiter_if #(
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32,
    parameter int p_dom_nbits  = 2
);
    // dma_val/dma_rdy: a command transfers on a cycle where both are high; the
    // master holds dma_val and all command fields stable until that cycle.
    // dma_ack is a single-cycle completion strobe qualifying dma_data, and
    // dma_abort is a single-cycle strobe cancelling the outstanding command.
    logic                    dma_val;
    logic                    dma_rdy;
    logic [p_dom_nbits-1:0]  dma_domain;
    logic [p_addr_nbits-1:0] dma_src_addr;
    logic [p_addr_nbits-1:0] dma_dest_addr;
    logic                    dma_inst;
    logic                    dma_ack;
    logic [p_data_nbits-1:0] dma_data;
    logic                    dma_abort;

    modport master (
        output dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_inst, dma_abort,
        input  dma_rdy, dma_ack, dma_data
    );

    modport slave (
        input  dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_inst, dma_abort,
        output dma_rdy, dma_ack, dma_data
    );

endinterface

// File: rtl/plab5_mcore_rr_arbiter.sv
// Round-robin picker: lowest-indexed request at or above ptr, wrapping to the
// lowest request overall. Produces a one-hot grant and its encoded index.
module plab5_mcore_rr_arbiter
    import plab5_mcore_dma_sec_arbiter_pkg::*;
#(
    parameter int p_num = 2,
    localparam int c_idx_nbits = idx_nbits(p_num)
) (
    input  logic [p_num-1:0]       req,
    input  logic [c_idx_nbits-1:0] ptr,
    output logic [p_num-1:0]       grant,
    output logic [c_idx_nbits-1:0] grant_idx,
    output logic                   grant_val
);

    logic [p_num-1:0] hi_req;
    logic [p_num-1:0] pick;

    always_comb begin
        hi_req    = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < p_num; i++) begin
            hi_req[i] = req[i] && (c_idx_nbits'(i) >= ptr);
        end
        // No request at or above the pointer means the search wraps around.
        pick = (|hi_req) ? hi_req : req;
        for (int i = p_num - 1; i >= 0; i--) begin
            if (pick[i]) grant_idx = c_idx_nbits'(i);
        end
        grant_val = |req;
        if (grant_val) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/plab5_mcore_dma_sec_arbiter.sv
// Round-robin DMA command arbiter with a run-time security-level gate and a
// WAIT timeout. Define PLAB5_DMA_SEC_ARBITER_DENY_LOG_EN to add deny logging.
module plab5_mcore_dma_sec_arbiter
    import plab5_mcore_dma_sec_arbiter_pkg::*;
#(
    parameter int p_num_req    = 2,
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32,
    parameter int p_dom_nbits  = 2,
    parameter logic [p_dom_nbits-1:0] p_sec_reset = '1,
    parameter int p_timeout    = 255,
    localparam int c_idx_nbits = idx_nbits(p_num_req)
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [p_num_req-1:0]              req_val,
    output logic [p_num_req-1:0]              req_rdy,
    input  logic [p_num_req*p_dom_nbits-1:0]  req_domain,
    input  logic [p_num_req*p_addr_nbits-1:0] req_src_addr,
    input  logic [p_num_req*p_addr_nbits-1:0] req_dest_addr,
    input  logic [p_num_req-1:0]              req_inst,

    output logic [p_num_req-1:0]              resp_val,
    output logic [1:0]                        resp_status,
    output logic [p_data_nbits-1:0]           resp_data,
    output logic [p_dom_nbits-1:0]            resp_domain,

    input  logic                              sec_wr_en,
    input  logic [p_dom_nbits-1:0]            sec_wr_domain,
    input  logic [p_dom_nbits-1:0]            sec_wr_level,
    output logic [p_dom_nbits-1:0]            sec_level,

    plab5_mcore_dma_sec_arbiter_if.master     dma,

    output state_t                            dbg_state
`ifdef PLAB5_DMA_SEC_ARBITER_DENY_LOG_EN
    ,
    output logic [15:0]                       deny_count,
    output logic [c_idx_nbits-1:0]            last_deny_chan
`endif
);

    localparam logic [c_cnt_nbits-1:0] c_timeout  = c_cnt_nbits'(p_timeout);
    localparam logic [c_idx_nbits-1:0] c_last_idx = c_idx_nbits'(p_num_req - 1);

    state_t                   state_q, state_n;
    logic [c_idx_nbits-1:0]   ptr_q, g_q;
    logic [p_dom_nbits-1:0]   dom_q, sec_q;
    logic [p_addr_nbits-1:0]  src_q, dest_q;
    logic                     inst_q;
    status_t                  status_q;
    logic [p_data_nbits-1:0]  data_q;
    logic [c_cnt_nbits-1:0]   cnt_q;

    logic [p_num_req-1:0]     grant;
    logic [c_idx_nbits-1:0]   grant_idx;
    logic                     grant_val;

    logic [p_dom_nbits-1:0]   sel_domain;
    logic [p_addr_nbits-1:0]  sel_src, sel_dest;
    logic                     sel_inst;

    plab5_mcore_rr_arbiter #(.p_num(p_num_req)) u_rr (
        .req       (req_val),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_val (grant_val)
    );

    // One-hot mux of the granted channel's command fields.
    always_comb begin
        sel_domain = '0;
        sel_src    = '0;
        sel_dest   = '0;
        sel_inst   = 1'b0;
        for (int i = 0; i < p_num_req; i++) begin
            if (grant[i]) begin
                sel_domain = `PLAB5_SLICE(req_domain, i, p_dom_nbits);
                sel_src    = `PLAB5_SLICE(req_src_addr, i, p_addr_nbits);
                sel_dest   = `PLAB5_SLICE(req_dest_addr, i, p_addr_nbits);
                sel_inst   = req_inst[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (grant_val) state_n = ST_CHECK;
            ST_CHECK: state_n = (dom_q >= sec_q) ? ST_REQ : ST_RESP;
            ST_REQ:   if (dma.dma_rdy) state_n = ST_WAIT;
            ST_WAIT:  if (dma.dma_ack || (cnt_q == c_timeout)) state_n = ST_RESP;
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Strobes are masked during reset so an abandoned command never reports.
    always_comb begin
        req_rdy           = '0;
        resp_val          = '0;
        resp_status       = '0;
        resp_data         = '0;
        resp_domain       = '0;
        dma.dma_val       = 1'b0;
        dma.dma_domain    = '0;
        dma.dma_src_addr  = '0;
        dma.dma_dest_addr = '0;
        dma.dma_inst      = 1'b0;
        dma.dma_abort     = 1'b0;
        case (state_q)
            ST_IDLE: if (!reset) req_rdy = grant;
            ST_REQ: begin
                dma.dma_val       = 1'b1;
                dma.dma_domain    = dom_q;
                dma.dma_src_addr  = src_q;
                dma.dma_dest_addr = dest_q;
                dma.dma_inst      = inst_q;
            end
            ST_WAIT: dma.dma_abort = !reset && !dma.dma_ack && (cnt_q == c_timeout);
            ST_RESP: begin
                resp_val[g_q] = !reset;
                resp_status   = status_q;
                resp_data     = (status_q == STATUS_OK) ? data_q : '0;
                resp_domain   = dom_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            g_q      <= '0;
            dom_q    <= '0;
            src_q    <= '0;
            dest_q   <= '0;
            inst_q   <= 1'b0;
            status_q <= STATUS_OK;
            data_q   <= '0;
            cnt_q    <= '0;
            sec_q    <= p_sec_reset;
        end else begin
            // A CHECK in this same cycle still compares against the old sec_q.
            if (sec_wr_en && (sec_wr_domain >= sec_q)) sec_q <= sec_wr_level;
            case (state_q)
                ST_IDLE: if (grant_val) begin
                    g_q    <= grant_idx;
                    dom_q  <= sel_domain;
                    src_q  <= sel_src;
                    dest_q <= sel_dest;
                    inst_q <= sel_inst;
                end
                ST_CHECK: status_q <= (dom_q >= sec_q) ? STATUS_OK : STATUS_DENIED;
                ST_REQ:   if (dma.dma_rdy) cnt_q <= '0;
                ST_WAIT: begin
                    if (dma.dma_ack) begin
                        data_q   <= dma.dma_data;
                        status_q <= STATUS_OK;
                    end else if (cnt_q == c_timeout) begin
                        status_q <= STATUS_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: ptr_q <= (g_q == c_last_idx) ? '0 : g_q + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PLAB5_DMA_SEC_ARBITER_DENY_LOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            deny_count     <= '0;
            last_deny_chan <= '0;
        end else if ((state_q == ST_RESP) && (status_q != STATUS_OK)) begin
            if (deny_count != 16'hFFFF) deny_count <= deny_count + 16'd1;
            last_deny_chan <= g_q;
        end
    end
`endif

    assign sec_level = sec_q;
    assign dbg_state = state_q;

endmodule

// File: doc/plab5_mcore_dma_sec_arbiter.md
Name: plab5_mcore_dma_sec_arbiter

Overview:
- Parametrised, multi-channel successor to the single-NoC/single-debug DMA security checker.
- Accepts DMA commands from p_num_req requesters and arbitrates them round-robin.
- Checks each command's multi-bit domain against a run-time-writable security level, then forwards allowed commands to the DMA controller.
- Returns a per-requester response with status OK, DENIED or TIMEOUT. Sits between the NoC/debug fabric and the DMA controller.

Parameters:
- p_num_req, 2, number of requester channels (1..8).
- p_addr_nbits, 32, address width.
- p_data_nbits, 32, response data width.
- p_dom_nbits, 2, security domain width.
- p_sec_reset, all ones, security level after reset.
- p_timeout, 255, maximum cycles in WAIT before abort (1..2^16-1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_val  in  N  per-channel request valid.
- req_rdy  out  N  per-channel accept; one-hot or zero.
- req_domain  in  N*p_dom_nbits  per-channel domain; channel i occupies slice [i*D +: D].
- req_src_addr  in  N*p_addr_nbits  per-channel source address.
- req_dest_addr  in  N*p_addr_nbits  per-channel destination address.
- req_inst  in  N  per-channel instruction/debug flag.
- resp_val  out  N  one-cycle response pulse to the granted channel.
- resp_status  out  2  0=OK, 1=DENIED, 2=TIMEOUT.
- resp_data  out  p_data_nbits  DMA return data; zero unless OK.
- resp_domain  out  p_dom_nbits  domain of the responded command.
- sec_wr_en  in  1  security-level write strobe.
- sec_wr_domain  in  p_dom_nbits  domain of the writer.
- sec_wr_level  in  p_dom_nbits  new security level.
- sec_level  out  p_dom_nbits  current security level.
- dma_val  out  1  command valid to DMA.
- dma_rdy  in  1  DMA accepts command.
- dma_domain  out  p_dom_nbits  forwarded domain.
- dma_src_addr  out  p_addr_nbits  forwarded source address.
- dma_dest_addr  out  p_addr_nbits  forwarded destination address.
- dma_inst  out  1  forwarded instruction/debug flag.
- dma_ack  in  1  DMA completion.
- dma_data  in  p_data_nbits  DMA return data, valid with dma_ack.
- dma_abort  out  1  one-cycle abort pulse on timeout.

Behaviour:
- Reset: state IDLE, rr pointer 0, sec_level = p_sec_reset, timeout counter 0. All val/rdy/ack/abort outputs are 0; data, address and status outputs are 0.
- States: IDLE, CHECK, REQ, WAIT, RESP.
- IDLE: grant the lowest-indexed requester with req_val set, searching from the rr pointer upward with wrap-around. Assert req_rdy[g] combinationally in the same cycle. Latch domain, src, dest and inst; latch g. Go to CHECK. With no req_val, stay in IDLE.
- CHECK (1 cycle): if latched domain >= sec_level (unsigned), go to REQ; else go to RESP with status DENIED. A DENIED command never asserts dma_val.
- REQ: hold dma_val and the latched fields until dma_rdy is seen, then go to WAIT and clear the timeout counter.
- WAIT: on dma_ack, capture dma_data, set status OK, go to RESP. If the counter reaches p_timeout first, pulse dma_abort, set status TIMEOUT, go to RESP. If dma_ack arrives in the same cycle as expiry, dma_ack wins and status is OK.
- RESP (1 cycle): resp_val[g]=1 with resp_status, resp_data and resp_domain. Set rr pointer = (g+1) mod N. Return to IDLE.
- Any dma_ack outside WAIT is ignored.
- Allowed-path minimum latency: grant to resp_val = 4 cycles (grant, CHECK, REQ with dma_rdy=1, WAIT with dma_ack=1, then RESP).
- Security write: accepted only if sec_wr_domain >= sec_level; otherwise silently ignored.
  - An accepted write updates sec_level at the next clock edge.
  - A CHECK in the same cycle as the write uses the old value.
- Reset mid-operation: abandon the transaction; no resp_val and no dma_abort are issued.

Optional Feature:
- Macro: PLAB5_DMA_SEC_ARBITER_DENY_LOG_EN.
- When defined, add two outputs:
  - deny_count (16-bit, saturating): increments on each DENIED or TIMEOUT response; reset 0.
  - last_deny_chan ($clog2(p_num_req) bits; 1 bit when p_num_req=1): index of the last denied or timed-out channel; reset 0.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package/header plab5_mcore_dma_sec_defs: state encodings, status codes (OK/DENIED/TIMEOUT), slice macros for the flattened per-channel buses.
- One sub-module: plab5_mcore_rr_arbiter. Parametrised on N; takes a request vector and pointer, produces a one-hot grant and an encoded index.

Test Plan:
- N=2, sec_level=1: ch0 domain 2 with dma_rdy=1 and dma_ack after 3 cycles, dma_data=0xCAFE -> dma_val once; resp_val[0] with status OK and resp_data 0xCAFE.
- ch1 domain 0, sec_level=1 -> resp_val[1] with status DENIED two cycles after grant, dma_val never asserted, resp_data 0.
- Both channels valid continuously, all domains 3 -> grants alternate 0,1,0,1 over four transactions.
- p_timeout=4, dma_ack never arrives -> dma_abort pulses exactly 4 cycles after entering WAIT; status TIMEOUT. A dma_ack 2 cycles later is ignored.
- sec_level=2: write of level 3 from domain 1 -> ignored, stays 2. Write from domain 3 coincident with a CHECK of a domain-2 command -> command allowed; sec_level becomes 3 on the next cycle.
- Assert reset during WAIT -> next cycle state IDLE, sec_level=p_sec_reset, no resp_val and no dma_abort.
